// File: rtl/cplx_mac_pkg.sv
// Shared types, default parameters and the saturation helper for the
// multi-channel complex MAC.
package cplx_mac_pkg;

  localparam int AW_DEF    = 18;
  localparam int BW_DEF    = 18;
  localparam int PW_DEF    = 48;
  localparam int OW_DEF    = 32;
  localparam int SHIFT_DEF = 0;
  localparam int NCH_DEF   = 4;

  // Widest accumulator the saturation helper can handle
  localparam int MAXW = 128;

  typedef logic signed [MAXW-1:0] wide_t;

  typedef struct packed {
    wide_t re;
    wide_t im;
  } cplx_wide_t;

  // Clamp v into the signed range of an ow-bit number; clip reports clamping
  function automatic wide_t saturate(input wide_t v, input int ow, output logic clip);
    wide_t hi;
    wide_t lo;
    wide_t res;
    hi = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    clip = 1'b0;
    res = v;
    if (v > hi) begin
      res = hi;
      clip = 1'b1;
    end else if (v < lo) begin
      res = lo;
      clip = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cplx_mac_multi_mul.sv
// Two-stage complex multiplier: registered operands, then registered
// exact real/imaginary products at AW+BW+1 bits.
module cplx_mul_pipe
  import cplx_mac_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int BW = BW_DEF,
  localparam int MW = AW + BW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic signed [AW-1:0] ar,
  input  logic signed [AW-1:0] ai,
  input  logic signed [BW-1:0] br,
  input  logic signed [BW-1:0] bi,
  output logic signed [MW-1:0] re,
  output logic signed [MW-1:0] im
);

  logic signed [AW-1:0] a_r, a_i;
  logic signed [BW-1:0] b_r, b_i;
  logic signed [MW-1:0] p_rr, p_ii, p_ri, p_ir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      a_i <= '0;
      b_r <= '0;
      b_i <= '0;
    end else if (en) begin
      a_r <= ar;
      a_i <= ai;
      b_r <= br;
      b_i <= bi;
    end
  end

  // Every partial product fits in AW+BW bits, so MW-bit arithmetic is exact
  always_comb begin
    p_rr = MW'(a_r) * MW'(b_r);
    p_ii = MW'(a_i) * MW'(b_i);
    p_ri = MW'(a_r) * MW'(b_i);
    p_ir = MW'(a_i) * MW'(b_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re <= '0;
      im <= '0;
    end else begin
      re <= p_rr - p_ii;
      im <= p_ri + p_ir;
    end
  end

endmodule

// File: rtl/cplx_mac_multi.sv
// Multi-channel interleaved complex multiply-accumulate, 4-cycle result latency.
// Define CPLX_MAC_SAT_EN to saturate outputs and report clipping on ovf.
module cplx_mac_multi
  import cplx_mac_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int BW    = BW_DEF,
  parameter int PW    = PW_DEF,
  parameter int OW    = OW_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int NCH   = NCH_DEF,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [CW-1:0]        in_ch,
  input  logic signed [AW-1:0] ar,
  input  logic signed [AW-1:0] ai,
  input  logic signed [BW-1:0] br,
  input  logic signed [BW-1:0] bi,
  output logic                 out_valid,
  output logic [CW-1:0]        out_ch,
  output logic signed [OW-1:0] pr,
  output logic signed [OW-1:0] pi,
  output logic                 ovf
);

  localparam int MW = AW + BW + 1;
  localparam logic [CW:0] NCH_V = (CW + 1)'(NCH);

  if (PW < AW + BW + 1) begin : g_err_pw
    $error("cplx_mac_multi: PW must be at least AW+BW+1");
  end
  if (OW > PW) begin : g_err_ow
    $error("cplx_mac_multi: OW must not exceed PW");
  end
  if (SHIFT > PW - OW) begin : g_err_shift
    $error("cplx_mac_multi: SHIFT must not exceed PW-OW");
  end
  if (NCH < 1) begin : g_err_nch
    $error("cplx_mac_multi: NCH must be at least 1");
  end
  if (PW > MAXW) begin : g_err_maxw
    $error("cplx_mac_multi: PW exceeds supported width");
  end

  logic                 in_ok;
  logic                 v1, first1, last1;
  logic [CW-1:0]        ch1;
  logic                 v2, first2, last2;
  logic [CW-1:0]        ch2;
  logic signed [MW-1:0] prod_re, prod_im;

  // Out-of-range channels never enter the pipeline
  assign in_ok = in_valid && ({1'b0, in_ch} < NCH_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      ch1    <= '0;
      v2     <= 1'b0;
      first2 <= 1'b0;
      last2  <= 1'b0;
      ch2    <= '0;
    end else begin
      v1 <= in_ok;
      if (in_ok) begin
        first1 <= in_first;
        last1  <= in_last;
        ch1    <= in_ch;
      end
      v2     <= v1;
      first2 <= first1;
      last2  <= last1;
      ch2    <= ch1;
    end
  end

  cplx_mul_pipe #(
    .AW(AW),
    .BW(BW)
  ) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (in_ok),
    .ar   (ar),
    .ai   (ai),
    .br   (br),
    .bi   (bi),
    .re   (prod_re),
    .im   (prod_im)
  );

  logic signed [PW-1:0] acc_re [NCH];
  logic signed [PW-1:0] acc_im [NCH];
  logic signed [PW-1:0] base_re, base_im, sum_re, sum_im;
  logic                 s3_valid;
  logic [CW-1:0]        s3_ch;
  logic signed [PW-1:0] s3_re, s3_im;

  always_comb begin
    base_re = '0;
    base_im = '0;
    if (!first2) begin
      base_re = acc_re[ch2];
      base_im = acc_im[ch2];
    end
    sum_re = base_re + PW'(prod_re);
    sum_im = base_im + PW'(prod_im);
  end

  // Read-modify-write in one cycle lets a channel take samples back to back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        acc_re[i] <= '0;
        acc_im[i] <= '0;
      end
      s3_valid <= 1'b0;
      s3_ch    <= '0;
      s3_re    <= '0;
      s3_im    <= '0;
    end else begin
      s3_valid <= v2 && last2;
      if (v2) begin
        acc_re[ch2] <= sum_re;
        acc_im[ch2] <= sum_im;
      end
      if (v2 && last2) begin
        s3_ch <= ch2;
        s3_re <= sum_re;
        s3_im <= sum_im;
      end
    end
  end

  logic signed [OW-1:0] post_re, post_im;
  logic                 s4_valid;
  logic [CW-1:0]        s4_ch;
  logic signed [OW-1:0] s4_re, s4_im;

`ifdef CPLX_MAC_SAT_EN
  cplx_wide_t shifted;
  logic       clip_re, clip_im;
  logic       post_ovf;
  logic       s4_ovf;

  always_comb begin
    shifted.re = wide_t'(s3_re) >>> SHIFT;
    shifted.im = wide_t'(s3_im) >>> SHIFT;
    clip_re    = 1'b0;
    clip_im    = 1'b0;
    post_re    = OW'(saturate(shifted.re, OW, clip_re));
    post_im    = OW'(saturate(shifted.im, OW, clip_im));
    post_ovf   = clip_re || clip_im;
  end
`else
  always_comb begin
    post_re = OW'(s3_re >>> SHIFT);
    post_im = OW'(s3_im >>> SHIFT);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s4_valid <= 1'b0;
      s4_ch    <= '0;
      s4_re    <= '0;
      s4_im    <= '0;
`ifdef CPLX_MAC_SAT_EN
      s4_ovf   <= 1'b0;
`endif
    end else begin
      s4_valid <= s3_valid;
      if (s3_valid) begin
        s4_ch <= s3_ch;
        s4_re <= post_re;
        s4_im <= post_im;
`ifdef CPLX_MAC_SAT_EN
        s4_ovf <= post_ovf;
`endif
      end
    end
  end

  // Result fields hold their last value between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      pr        <= '0;
      pi        <= '0;
`ifdef CPLX_MAC_SAT_EN
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= s4_valid;
      if (s4_valid) begin
        out_ch <= s4_ch;
        pr     <= s4_re;
        pi     <= s4_im;
`ifdef CPLX_MAC_SAT_EN
        ovf    <= s4_ovf;
`endif
      end
    end
  end

`ifndef CPLX_MAC_SAT_EN
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cplx_mac_multi.sv
// Directed bench for cplx_mac_multi (OW=8, NCH=3 so channel 3 is out of range).
module tb_cplx_mac_multi;

  localparam int AW    = 18;
  localparam int BW    = 18;
  localparam int PW    = 48;
  localparam int OW    = 8;
  localparam int SHIFT = 0;
  localparam int NCH   = 3;
  localparam int CW    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_first = 1'b0;
  logic                 in_last = 1'b0;
  logic [CW-1:0]        in_ch = '0;
  logic signed [AW-1:0] ar = '0;
  logic signed [AW-1:0] ai = '0;
  logic signed [BW-1:0] br = '0;
  logic signed [BW-1:0] bi = '0;
  logic                 out_valid;
  logic [CW-1:0]        out_ch;
  logic signed [OW-1:0] pr;
  logic signed [OW-1:0] pi;
  logic                 ovf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cplx_mac_multi #(
    .AW(AW), .BW(BW), .PW(PW), .OW(OW), .SHIFT(SHIFT), .NCH(NCH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_first (in_first),
    .in_last  (in_last),
    .in_ch    (in_ch),
    .ar       (ar),
    .ai       (ai),
    .br       (br),
    .bi       (bi),
    .out_valid(out_valid),
    .out_ch   (out_ch),
    .pr       (pr),
    .pi       (pi),
    .ovf      (ovf)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int ch, input logic f, input logic l,
                      input int a_r, input int a_i, input int b_r, input int b_i);
    @(negedge clk);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_ch    = CW'(ch);
    ar       = AW'(a_r);
    ai       = AW'(a_i);
    br       = BW'(b_r);
    bi       = BW'(b_i);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Result must appear on the 5th negedge after the last sample was driven
  task automatic expect_out(input string tag, input int ch, input int epr, input int epi, input int eovf);
    for (int i = 1; i <= 4; i++) begin
      idle();
      chk({tag, "_early"}, out_valid, 0);
    end
    idle();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_ch"}, out_ch, ch);
    chk({tag, "_pr"}, pr, epr);
    chk({tag, "_pi"}, pi, epi);
    chk({tag, "_ovf"}, ovf, eovf);
    idle();
    chk({tag, "_strobe"}, out_valid, 0);
    chk({tag, "_hold"}, pr, epr);
  endtask

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_pr", pr, 0);
    chk("rst_pi", pi, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-sample frame: (3+2j)(4-1j) = 14+5j
    send(0, 1, 1, 3, 2, 4, -1);
    expect_out("single", 0, 14, 5, 0);

    // Three (1+j)(1+j)=2j samples, with an ignored idle cycle carrying junk
    send(1, 1, 0, 1, 1, 1, 1);
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b1; in_last = 1'b1; in_ch = 2'd1;
    ar = 18'sd77; ai = 18'sd55; br = 18'sd33; bi = 18'sd11;
    send(1, 0, 0, 1, 1, 1, 1);
    send(1, 0, 1, 1, 1, 1, 1);
    expect_out("triple", 1, 0, 6, 0);

    // Interleaved: ch0 = 2 + (1+j) = 3+j, ch1 = -1 + 6j = -1+6j
    send(0, 1, 0, 1, 0, 2, 0);
    send(1, 1, 0, 0, 1, 0, 1);
    send(0, 0, 1, 1, 1, 1, 0);
    send(1, 0, 1, 2, 0, 0, 3);
    for (int i = 1; i <= 3; i++) begin
      idle();
      chk("ilv_early", out_valid, 0);
    end
    idle();
    chk("ilv0_valid", out_valid, 1);
    chk("ilv0_ch", out_ch, 0);
    chk("ilv0_pr", pr, 3);
    chk("ilv0_pi", pi, 1);
    idle();
    chk("ilv1_valid", out_valid, 1);
    chk("ilv1_ch", out_ch, 1);
    chk("ilv1_pr", pr, -1);
    chk("ilv1_pi", pi, 6);
    idle();
    chk("ilv_end", out_valid, 0);

    // 100*100 = 10000 exceeds an 8-bit output
    send(2, 1, 1, 100, 0, 100, 0);
`ifdef CPLX_MAC_SAT_EN
    expect_out("sat", 2, 127, 0, 1);
`else
    expect_out("wrap", 2, 16, 0, 0);
`endif

    // Channel 3 is beyond NCH: no output, no accumulator change
    send(3, 1, 1, 5, 0, 5, 0);
    for (int i = 1; i <= 6; i++) begin
      idle();
      chk("badch_none", out_valid, 0);
    end
    send(0, 0, 1, 0, 0, 0, 0);
    expect_out("badch_acc", 0, 3, 1, 0);

    // Reset 2 cycles after a last sample discards it
    send(1, 1, 1, 5, 0, 5, 0);
    idle();
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_pr", pr, 0);
    chk("mid_rst_pi", pi, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      idle();
      chk("rst_drop", out_valid, 0);
    end

    // Sample driven together with reset release is taken on the first edge
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_ch = 2'd1;
    ar = 18'sd2; ai = 18'sd0; br = 18'sd3; bi = 18'sd0;
    expect_out("post_rst", 1, 6, 0, 0);

    // Accumulator was cleared by reset, so last-only returns the sample alone
    send(0, 0, 1, 1, 0, 1, 0);
    expect_out("cleared", 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cplx_mac_multi.md
CPLX_MAC_MULTI -- requirements
Module: cplx_mac_multi

Interface
REQ-001 SHALL have parameter AW, default 18, operand A component width (signed).
REQ-002 SHALL have parameter BW, default 18, operand B component width (signed).
REQ-003 SHALL have parameter PW, default 48, accumulator width; elaboration error if PW < AW+BW+1.
REQ-004 SHALL have parameter OW, default 32, output component width; elaboration error if OW > PW.
REQ-005 SHALL have parameter SHIFT, default 0, arithmetic right shift applied at output; elaboration error if SHIFT > PW-OW.
REQ-006 SHALL have parameter NCH, default 4, number of interleaved channels (>=1); CW = max(1,$clog2(NCH)).
REQ-007 SHALL have ports, in this order: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-008 SHALL have in_valid input 1, sample qualifier; in_first input 1, restart accumulation (replaces old sload); in_last input 1, close accumulation and emit result.
REQ-009 SHALL have in_ch input CW, channel index; ar, ai input AW signed; br, bi input BW signed.
REQ-010 SHALL have out_valid output 1, one-cycle result strobe; out_ch output CW, channel of result.
REQ-011 SHALL have pr, pi output OW signed, result components; ovf output 1, overflow flag qualified by out_valid.

Function
REQ-012 SHALL sample inputs only on clk edges where in_valid=1; when in_valid=0, all other inputs are ignored.
REQ-013 SHALL compute per sample re = ar*br - ai*bi and im = ar*bi + ai*br at AW+BW+1 bits, exactly.
REQ-014 SHALL keep an independent PW-bit complex accumulator per channel: acc[ch] <= (in_first ? 0 : acc[ch]) + {re,im}, sign-extended, two's-complement wrap at PW.
REQ-015 SHALL perform read-modify-write of acc[ch] in a single stage, so back-to-back samples on the same channel accumulate correctly without stalls.
REQ-016 SHALL, for a sample with in_last=1, assert out_valid exactly 4 cycles after the sampling edge, with out_ch = in_ch and pr/pi = final acc >>> SHIFT reduced to OW bits.
REQ-017 SHALL, for in_first=1 and in_last=1 on the same sample, output that sample's product alone.
REQ-018 SHALL, for in_last=1 without a prior in_first, continue from the current accumulator contents.
REQ-019 SHALL ignore samples with in_ch >= NCH: no accumulator update, no output.
REQ-020 SHALL accept one sample per cycle, fully pipelined; out_valid may assert on consecutive cycles.
REQ-021 SHALL hold pr, pi, out_ch and ovf at their last values while out_valid=0.

Reset
REQ-022 SHALL, while rst_n=0, clear all accumulators, pipeline valid bits, out_valid, out_ch, pr, pi and ovf to 0 immediately.
REQ-023 SHALL discard in-flight samples on reset mid-operation; no out_valid for them after rst_n rises.
REQ-024 SHALL accept a sample on the first rising clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with CPLX_MAC_SAT_EN defined, saturate each shifted component to [-2^(OW-1), 2^(OW-1)-1] and set ovf=1 when either component clipped.
REQ-026 SHALL, without CPLX_MAC_SAT_EN, truncate to the low OW bits (wrap) and drive ovf constant 0.

Structure
REQ-027 SHALL place a complex-pair typedef, default parameter constants and the saturate function in package cplx_mac_pkg.
REQ-028 SHALL instantiate sub-module cplx_mul_pipe (registered inputs plus registered products, 2 cycles) for the multiply; accumulate and output stages in the top.

Verification
REQ-029 SHALL cover: ch0, first=1/last=1, ar=3 ai=2 br=4 bi=-1 -> 4 cycles later out_valid=1, out_ch=0, pr=14, pi=5.
REQ-030 SHALL cover: ch1, three samples (1,1)x(1,1) with first on sample 1 and last on sample 3 -> pr=0, pi=6.
REQ-031 SHALL cover: interleaved ch0/ch1/ch0/ch1 with first/last framing -> two outputs, each equal to its own channel sum only.
REQ-032 SHALL cover: with CPLX_MAC_SAT_EN, OW=8, SHIFT=0, ar=br=100, ai=bi=0 -> pr=127, pi=0, ovf=1; without the macro -> pr=16, ovf=0.
REQ-033 SHALL cover: rst_n pulsed low 2 cycles after a last sample -> no out_valid; next first/last sample returns its product alone.
REQ-034 SHALL cover: in_ch=NCH with in_valid=1, in_last=1 -> no out_valid; accumulators unchanged.
